// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry, special register
// numbers and the write-destination select encodings.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int CNT_WIDTH  = 2;

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic [4:0] RA_REG   = 5'd31;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } dst_sel_e;

    // Destination register for a given select; jal writes the link register.
    function automatic logic [4:0] sel_dest(dst_sel_e sel, logic [4:0] rt, logic [4:0] rd);
        case (sel)
            DST_RT:  return rt;
            DST_RD:  return rd;
            default: return RA_REG;
        endcase
    endfunction

endpackage

// File: rtl/reg_pend_counter.sv
// Saturating up/down counter of outstanding writes to one register.
// A simultaneous claim and retire cancel out, even at saturation.
module reg_pend_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    assign ovf = inc && !dec && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// MIPS register file with write-back bypass on both read ports and a
// per-register pending-write scoreboard for decode hazard detection.
module reg_file_wb #(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = mips_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  pend_a,
    output logic                  pend_b,
    input  logic                  claim_en,
    input  logic [ADDR_WIDTH-1:0] claim_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ovf_err
);

    import mips_pkg::*;

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt  [NUM_REGS];
    logic [NUM_REGS-1:0]   ovf_vec;
    logic                  wr_live;

    logic [CNT_WIDTH-1:0]  cnt_a;
    logic [CNT_WIDTH-1:0]  cnt_b;
    logic                  retire_a;
    logic                  retire_b;

    assign wr_live = wr_en && (wr_addr != ZERO_ADDR);

    // Register 0 is never written, so it reads back as zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign cnt[0]     = '0;
    assign ovf_vec[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
        reg_pend_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (claim_en && (claim_addr == ADDR_WIDTH'(g))),
            .dec   (wr_en && (wr_addr == ADDR_WIDTH'(g))),
            .cnt   (cnt[g]),
            .ovf   (ovf_vec[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (|ovf_vec) begin
            ovf_err <= 1'b1;
        end
    end

    // A write retiring in this cycle already hides its own pending count.
    always_comb begin
        rd_data_a = (wr_live && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
        rd_data_b = (wr_live && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];

        cnt_a    = cnt[rd_addr_a];
        cnt_b    = cnt[rd_addr_b];
        retire_a = wr_en && (wr_addr == rd_addr_a) && (cnt_a != '0);
        retire_b = wr_en && (wr_addr == rd_addr_b) && (cnt_b != '0);
        pend_a   = (cnt_a - CNT_WIDTH'(retire_a)) != '0;
        pend_b   = (cnt_b - CNT_WIDTH'(retire_b)) != '0;
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomised plus directed bench for reg_file_wb against an array-based
// model of the register contents and outstanding-write counts.
module tb_reg_file_wb;

    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        pend_a;
    logic        pend_b;
    logic        claim_en = 1'b0;
    logic [4:0]  claim_addr = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        ovf_err;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_ovf;
    bit          check_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    reg_file_wb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .pend_a     (pend_a),
        .pend_b     (pend_b),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_cnt[r]  = 0;
        end
        m_ovf = 1'b0;
    end

    // Model state advances on the same edge as the design.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] <= '0;
                m_cnt[r]  <= 0;
            end
            m_ovf <= 1'b0;
        end else begin
            if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] <= wr_data;
            for (int r = 1; r < 32; r++) begin
                if (claim_en && claim_addr == 5'(r) && !(wr_en && wr_addr == 5'(r))) begin
                    if (m_cnt[r] == CNT_MAX) m_ovf <= 1'b1;
                    else m_cnt[r] <= m_cnt[r] + 1;
                end else if (wr_en && wr_addr == 5'(r) && !(claim_en && claim_addr == 5'(r))
                             && m_cnt[r] > 0) begin
                    m_cnt[r] <= m_cnt[r] - 1;
                end
            end
        end
    end

    function automatic logic [31:0] expRd(input logic [4:0] a);
        if (wr_en && wr_addr != 5'd0 && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic expPend(input logic [4:0] a);
        int ret;
        ret = (wr_en && wr_addr == a && m_cnt[a] > 0) ? 1 : 0;
        return (m_cnt[a] - ret) != 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("rd_data_a", rd_data_a, expRd(rd_addr_a));
            checkOutput("rd_data_b", rd_data_b, expRd(rd_addr_b));
            checkOutput("pend_a", 32'(pend_a), 32'(expPend(rd_addr_a)));
            checkOutput("pend_b", 32'(pend_b), 32'(expPend(rd_addr_b)));
            checkOutput("ovf_err", 32'(ovf_err), 32'(m_ovf));
        end
    end

    task automatic applyStimulus(input bit rst, input logic [4:0] ra, input logic [4:0] rb,
                                 input bit ce, input logic [4:0] ca,
                                 input bit we, input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst_n      = ~rst;
        rd_addr_a  = ra;
        rd_addr_b  = rb;
        claim_en   = ce;
        claim_addr = ca;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
    endtask

    task automatic waitMid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        check_en = 1'b1;

        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0);
            waitMid();
            checkOutput("reset_rd_a", rd_data_a, 32'h0);
            checkOutput("reset_rd_b", rd_data_b, 32'h0);
            checkOutput("reset_pend", 32'({pend_a, pend_b, ovf_err}), 32'h0);
        end

        applyStimulus(0, 31, 0, 0, 0, 1, 31, 32'hDEADBEEF);
        waitMid();
        checkOutput("bypass_ra", rd_data_a, 32'hDEADBEEF);
        applyStimulus(0, 31, 0, 0, 0, 0, 0, 0);
        waitMid();
        checkOutput("stored_ra", rd_data_a, 32'hDEADBEEF);

        applyStimulus(0, 0, 0, 1, 0, 1, 0, 32'h12345678);
        waitMid();
        checkOutput("r0_bypass", rd_data_a, 32'h0);
        checkOutput("r0_pend", 32'(pend_a), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitMid();
        checkOutput("r0_read", rd_data_b, 32'h0);
        checkOutput("r0_pend_next", 32'(pend_b), 32'h0);

        applyStimulus(0, 8, 0, 1, 8, 0, 0, 0);
        applyStimulus(0, 8, 0, 1, 8, 0, 0, 0);
        applyStimulus(0, 8, 0, 0, 0, 1, 8, 32'h0000A5A5);
        waitMid();
        checkOutput("r8_first_retire", 32'(pend_a), 32'h1);
        applyStimulus(0, 8, 0, 0, 0, 0, 0, 0);
        waitMid();
        checkOutput("r8_after_retire", 32'(pend_a), 32'h1);
        applyStimulus(0, 8, 0, 0, 0, 1, 8, 32'h5A5A0001);
        waitMid();
        checkOutput("r8_last_retire", 32'(pend_a), 32'h0);
        checkOutput("r8_bypass", rd_data_a, 32'h5A5A0001);

        for (int i = 0; i < 4; i++) applyStimulus(0, 5, 0, 1, 5, 0, 0, 0);
        applyStimulus(0, 5, 0, 1, 5, 1, 5, 32'h7);
        waitMid();
        checkOutput("r5_sat_ovf", 32'(ovf_err), 32'h1);
        checkOutput("r5_sat_pend", 32'(pend_a), 32'h1);
        applyStimulus(0, 5, 0, 0, 0, 1, 5, 32'h8);
        applyStimulus(0, 5, 0, 0, 0, 1, 5, 32'h9);
        applyStimulus(0, 5, 0, 0, 0, 1, 5, 32'hA);
        waitMid();
        checkOutput("r5_third_retire", 32'(pend_a), 32'h0);
        checkOutput("r5_ovf_sticky", 32'(ovf_err), 32'h1);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 5, 0, 0, 0, 0, 0, 0);
        waitMid();
        checkOutput("r5_ovf_reset", 32'(ovf_err), 32'h0);

        applyStimulus(0, 9, 0, 1, 9, 0, 0, 0);
        applyStimulus(0, 9, 0, 0, 0, 1, 9, 32'hFF);
        applyStimulus(1, 9, 9, 1, 9, 1, 9, 32'h1111);
        applyStimulus(0, 9, 9, 0, 0, 0, 0, 0);
        waitMid();
        checkOutput("r9_reset_data", rd_data_a, 32'h0);
        checkOutput("r9_reset_pend", 32'(pend_a), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] ra, rb, ca, wa;
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ca = 5'($urandom_range(0, 7));
            wa = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 99) == 0, ra, rb,
                          $urandom_range(0, 1) == 1, ca,
                          $urandom_range(0, 2) != 0, wa, $urandom);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        waitMid();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
